hps_frame_sequencer: RTL and testbench
======================================

// Module: hps_frame_sequencer
// PURPOSE
//  Schedules the single-port magnitude RAM of the harmonic product spectrum (HPS) stage.
//  - Write phase: lets FFT magnitude samples into the RAM.
//  - Read phase: issues harmonic read triples mag[k], mag[2k], mag[3k] for k = K_MIN..K_LAST.
//  Read data is tagged with k/harmonic for the downstream product/maximum logic.
//  Sits between the FFT output stream, the magnitude RAM and the HPS product/max-detect path.
// PARAMETERS
//  K_WIDTH     11  RAM address width; N = 2**K_WIDTH stored bins (lower half of the DFT)
//  K_MIN        1  first fundamental bin read (skips DC)
//  RD_LATENCY   1  RAM read latency in cycles (>=1); rd_* outputs delayed by this amount
// PORTS
//  clock      in   1          single clock, rising edge
//  reset_n    in   1          asynchronous active-low reset
//  fft_valid  in   1          magnitude sample present this cycle
//  fft_last   in   1          qualifies final sample of the FFT frame (with fft_valid)
//  fft_k      in   K_WIDTH+1  bin index of the sample (FFT user field)
//  ram_addr   out  K_WIDTH    RAM address (write or read)
//  ram_we     out  1          RAM write enable
//  ram_re     out  1          RAM read enable
//  rd_valid   out  1          RAM read data valid this cycle
//  rd_harm    out  2          harmonic index of rd data: 0=k, 1=2k, 2=3k (3=4k, see CONFIGURATION)
//  rd_k       out  K_WIDTH    fundamental bin of rd data
//  rd_last    out  1          final read of the frame
//  frame_done out  1          1-cycle pulse: frame fully read out
//  busy       out  1          high in READ/DRAIN
//  overrun    out  1          1-cycle pulse: FFT sample dropped because a read phase was in progress
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Applies at any time, incl. mid-read; the
//    in-flight rd_* pipeline is flushed (no rd_valid after reset).
//  - FSM states:
//    - IDLE: on fft_valid -> WRITE (that sample is written).
//    - WRITE: on fft_valid & fft_last -> READ.
//    - READ: after final read issued -> DRAIN.
//    - DRAIN: after RD_LATENCY cycles -> IDLE.
//    - A single fft_valid & fft_last in IDLE writes and goes straight to READ.
//  - Write path (IDLE/WRITE, combinational): ram_we = fft_valid & ~fft_k[K_WIDTH];
//    ram_addr = fft_k[K_WIDTH-1:0]. Upper-half bins are ignored, but fft_last on them still ends the frame.
//  - Read path (READ): one ram_re per cycle, no gaps.
//    - Order: for each k, h = 0, 1, 2 with addresses k, 2k, 3k.
//    - Addresses come from three accumulators stepped by +1/+2/+3 per k; no multipliers.
//  - K_LAST = floor((N-1)/HARMONICS), so every address < N (N=2048: K_LAST=682, 3*682=2046).
//  - Read-phase timing: the first ram_re falls in the cycle after the fft_last write.
//    - Total reads = (K_LAST-K_MIN+1)*HARMONICS.
//  - rd_valid/rd_harm/rd_k/rd_last are ram_re/h/k/last delayed exactly RD_LATENCY cycles.
//    frame_done pulses in the same cycle as rd_last.
//  - fft_valid in READ/DRAIN: no write, overrun pulses for one cycle, state unaffected.
//    fft_last there is ignored.
//  - ram_we and ram_re are never high in the same cycle.
// CONFIGURATION
//  - `define HPS_FOURTH_HARMONIC_EN: HARMONICS = 4.
//    - Each k reads k, 2k, 3k, 4k (h = 0..3).
//    - K_LAST = floor((N-1)/4) (N=2048: 511).
//  - Undefined: HARMONICS = 3; rd_harm never equals 3.
// STRUCTURE
//  - Package hps_pkg:
//    - FSM state enum {IDLE, WRITE, READ, DRAIN}
//    - HARMONICS constant, set by the macro
//    - k_last(K_WIDTH) constant function
//    - rd_harm width constant
//  - Sub-module hps_rd_tag_pipe: RD_LATENCY-deep register pipe carrying {valid, harm, k, last};
//    async-reset to 0.
// TESTING
//  1. Write 2048 samples k=0..2047, last on 2047.
//     -> ram_we on all 2048; first read addr 1, h=0; sequence 1,2,3,2,4,6,...
//     -> 2046 reads, last addrs 682,1364,2046.
//     -> rd_last & frame_done together, RD_LATENCY after the final ram_re.
//  2. Sample with fft_k=2100 (bit K_WIDTH set) -> no ram_we.
//     Same with fft_last -> READ still entered.
//  3. fft_valid pulses during READ -> overrun pulse per sample, no ram_we, read sequence unchanged.
//  4. reset_n low mid-READ (k=300) -> all outputs 0 immediately, no rd_valid afterwards.
//     Next frame starts clean from k=1.
//  5. Define HPS_FOURTH_HARMONIC_EN, repeat test 1 -> 2044 reads, final addrs 511,1022,1533,2044, rd_harm=3 seen.
//  6. RD_LATENCY=3 -> rd_valid exactly 3 cycles after each ram_re.
//     Back-to-back frames: next fft_valid accepted the cycle after frame_done.

Source files
------------

// File: rtl/hps_frame_sequencer_pkg.sv
// rtl/hps_frame_sequencer_pkg.sv - shared types/constants for the HPS frame sequencer; HPS_FOURTH_HARMONIC_EN selects four harmonics
package hps_pkg;

`ifdef HPS_FOURTH_HARMONIC_EN
    localparam int HARMONICS = 4;
`else
    localparam int HARMONICS = 3;
`endif

    // rd_harm width: wide enough for h = 0..3
    localparam int HARM_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } hps_state_e;

    // Largest fundamental whose highest harmonic still addresses a stored bin
    function automatic int k_last(input int k_width);
        return ((1 << k_width) - 1) / HARMONICS;
    endfunction

endpackage

// File: rtl/hps_frame_sequencer_if.sv
// rtl/hps_frame_sequencer_if.sv - FFT input, magnitude RAM control and tagged read-data signals of the HPS sequencer
interface hps_frame_sequencer_if
    import hps_pkg::*;
#(
    parameter int K_WIDTH = 11
);
    logic                fft_valid;
    logic                fft_last;
    logic [K_WIDTH:0]    fft_k;
    logic [K_WIDTH-1:0]  ram_addr;
    logic                ram_we;
    logic                ram_re;
    logic                rd_valid;
    logic [HARM_W-1:0]   rd_harm;
    logic [K_WIDTH-1:0]  rd_k;
    logic                rd_last;
    logic                frame_done;
    logic                busy;
    logic                overrun;

    // Sequencer side
    modport master (
        input  fft_valid, fft_last, fft_k,
        output ram_addr, ram_we, ram_re,
        output rd_valid, rd_harm, rd_k, rd_last,
        output frame_done, busy, overrun
    );

    // FFT source / RAM / product-max side
    modport slave (
        output fft_valid, fft_last, fft_k,
        input  ram_addr, ram_we, ram_re,
        input  rd_valid, rd_harm, rd_k, rd_last,
        input  frame_done, busy, overrun
    );
endinterface

// File: rtl/hps_frame_sequencer_rd_tag_pipe.sv
// rtl/hps_frame_sequencer_rd_tag_pipe.sv - fixed-depth register pipe aligning read tags with RAM read data
module hps_rd_tag_pipe #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tag_in,
    output logic [WIDTH-1:0] tag_out
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift tags one stage per cycle; reset flushes every in-flight tag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];
endmodule

// File: rtl/hps_frame_sequencer.sv
// rtl/hps_frame_sequencer.sv - HPS magnitude RAM scheduler: frame write, then harmonic read triples/quads; HPS_FOURTH_HARMONIC_EN adds 4k reads
module hps_frame_sequencer
    import hps_pkg::*;
#(
    parameter int K_WIDTH    = 11,
    parameter int K_MIN      = 1,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    hps_frame_sequencer_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    localparam logic [K_WIDTH-1:0] K_FIRST = K_WIDTH'(K_MIN);
    localparam logic [K_WIDTH-1:0] K_LAST  = K_WIDTH'(k_last(K_WIDTH));
    localparam logic [HARM_W-1:0]  H_LAST  = HARM_W'(HARMONICS - 1);
    localparam int                 DR_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DR_W-1:0]    DR_END  = DR_W'(RD_LATENCY - 1);
    localparam int                 TAG_W   = 1 + HARM_W + K_WIDTH + 1;

    logic [1:0]          state_q, state_d;
    logic [K_WIDTH-1:0]  k_q, k_d;
    logic [HARM_W-1:0]   h_q, h_d;
    logic [K_WIDTH-1:0]  acc1_q, acc1_d;
    logic [K_WIDTH-1:0]  acc2_q, acc2_d;
    logic [K_WIDTH-1:0]  acc3_q, acc3_d;
`ifdef HPS_FOURTH_HARMONIC_EN
    logic [K_WIDTH-1:0]  acc4_q, acc4_d;
`endif
    logic [DR_W-1:0]     dcnt_q, dcnt_d;

    logic                rd_phase;
    logic                busy_w;
    logic                last_rd;
    logic [K_WIDTH-1:0]  rd_addr;
    logic [TAG_W-1:0]    tag_in;
    logic [TAG_W-1:0]    tag_out;

    assign rd_phase = (state_q == ST_READ);
    assign busy_w   = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign last_rd  = rd_phase && (h_q == H_LAST) && (k_q == K_LAST);

    // Next-state: frame write, harmonic walk via per-harmonic accumulators, drain of the read pipe
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        h_d     = h_q;
        acc1_d  = acc1_q;
        acc2_d  = acc2_q;
        acc3_d  = acc3_q;
`ifdef HPS_FOURTH_HARMONIC_EN
        acc4_d  = acc4_q;
`endif
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (bus.fft_valid) begin
                    if (bus.fft_last) begin
                        state_d = ST_READ;
                        k_d     = K_FIRST;
                        h_d     = '0;
                        acc1_d  = K_FIRST;
                        acc2_d  = K_WIDTH'(2 * K_MIN);
                        acc3_d  = K_WIDTH'(3 * K_MIN);
`ifdef HPS_FOURTH_HARMONIC_EN
                        acc4_d  = K_WIDTH'(4 * K_MIN);
`endif
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                if (h_q == H_LAST) begin
                    h_d    = '0;
                    k_d    = k_q + K_WIDTH'(1);
                    acc1_d = acc1_q + K_WIDTH'(1);
                    acc2_d = acc2_q + K_WIDTH'(2);
                    acc3_d = acc3_q + K_WIDTH'(3);
`ifdef HPS_FOURTH_HARMONIC_EN
                    acc4_d = acc4_q + K_WIDTH'(4);
`endif
                    if (k_q == K_LAST) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = '0;
                    end
                end else begin
                    h_d = h_q + HARM_W'(1);
                end
            end
            ST_DRAIN: begin
                if (dcnt_q == DR_END) begin
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            h_q     <= '0;
            acc1_q  <= '0;
            acc2_q  <= '0;
            acc3_q  <= '0;
`ifdef HPS_FOURTH_HARMONIC_EN
            acc4_q  <= '0;
`endif
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            h_q     <= h_d;
            acc1_q  <= acc1_d;
            acc2_q  <= acc2_d;
            acc3_q  <= acc3_d;
`ifdef HPS_FOURTH_HARMONIC_EN
            acc4_q  <= acc4_d;
`endif
            dcnt_q  <= dcnt_d;
        end
    end

    // Pick the accumulator of the harmonic being read this cycle
    always_comb begin
        rd_addr = '0;
        case (h_q)
            2'd0:    rd_addr = acc1_q;
            2'd1:    rd_addr = acc2_q;
            2'd2:    rd_addr = acc3_q;
`ifdef HPS_FOURTH_HARMONIC_EN
            2'd3:    rd_addr = acc4_q;
`endif
            default: rd_addr = '0;
        endcase
    end

    // RAM port: reads own the port in READ, otherwise FFT samples pass straight through
    always_comb begin
        bus.ram_re   = rd_phase;
        bus.ram_we   = !busy_w && bus.fft_valid && !bus.fft_k[K_WIDTH];
        bus.ram_addr = '0;
        if (rd_phase) begin
            bus.ram_addr = rd_addr;
        end else if (!busy_w && bus.fft_valid) begin
            bus.ram_addr = bus.fft_k[K_WIDTH-1:0];
        end
    end

    assign bus.busy    = busy_w;
    assign bus.overrun = busy_w && bus.fft_valid;

    assign tag_in = {rd_phase, h_q, k_q, last_rd};

    hps_rd_tag_pipe #(
        .WIDTH (TAG_W),
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign {bus.rd_valid, bus.rd_harm, bus.rd_k, bus.rd_last} = tag_out;
    assign bus.frame_done = bus.rd_last;
endmodule

// File: tb/tb_hps_frame_sequencer.sv
// tb/tb_hps_frame_sequencer.sv - self-checking bench for hps_frame_sequencer against a cycle-timeline reference model
module tb_hps_frame_sequencer;
    localparam int KW   = 11;
    localparam int N    = 1 << KW;
    localparam int KMIN = 1;
    localparam int LAT  = 3;
`ifdef HPS_FOURTH_HARMONIC_EN
    localparam int H = 4;
`else
    localparam int H = 3;
`endif
    localparam int KLAST = (N - 1) / H;
    localparam int R     = (KLAST - KMIN + 1) * H;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int read_start = -1;
    int reads_seen = 0;
    int we_seen    = 0;
    int done_seen  = 0;

    bit          cur_v = 1'b0;
    bit          cur_l = 1'b0;
    logic [KW:0] cur_k = '0;

    always #5 clock = ~clock;

    hps_frame_sequencer_if #(.K_WIDTH(KW)) bus ();

    hps_frame_sequencer #(
        .K_WIDTH    (KW),
        .K_MIN      (KMIN),
        .RD_LATENCY (LAT)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A frame's reads occupy cycles read_start..read_start+R-1; tagged data trails by LAT
    function automatic bit exp_busy(input int c);
        return (read_start >= 0) && (c >= read_start) && (c < read_start + R + LAT);
    endfunction

    task automatic check_outputs();
        int rel;
        int j;
        bit b;
        bit re;
        bit rv;
        b   = exp_busy(cyc);
        rel = cyc - read_start;
        re  = b && (rel < R);
        j   = rel - LAT;
        rv  = b && (j >= 0);
        chk("busy", bus.busy, b);
        chk("ram_re", bus.ram_re, re);
        chk("ram_we", bus.ram_we, !b && cur_v && !cur_k[KW]);
        chk("we_re_excl", bus.ram_we & bus.ram_re, 0);
        chk("overrun", bus.overrun, b && cur_v);
        if (re) chk("rd_addr", bus.ram_addr, (KMIN + rel / H) * (rel % H + 1));
        else if (!b && cur_v) chk("wr_addr", bus.ram_addr, cur_k[KW-1:0]);
        else if (!reset_n) chk("rst_addr", bus.ram_addr, 0);
        chk("rd_valid", bus.rd_valid, rv);
        chk("rd_last", bus.rd_last, rv && (j == R - 1));
        chk("frame_done", bus.frame_done, rv && (j == R - 1));
        if (rv) begin
            chk("rd_k", bus.rd_k, KMIN + j / H);
            chk("rd_harm", bus.rd_harm, j % H);
        end
        if (!reset_n) begin
            chk("rst_rd_k", bus.rd_k, 0);
            chk("rst_rd_harm", bus.rd_harm, 0);
        end
        if (bus.ram_re === 1'b1) reads_seen++;
        if (bus.ram_we === 1'b1) we_seen++;
        if (bus.frame_done === 1'b1) done_seen++;
    endtask

    task automatic cycle(input bit v, input bit l, input int kk);
        logic [31:0] kv;
        kv    = kk;
        cur_v = v;
        cur_l = l;
        cur_k = kv[KW:0];
        bus.fft_valid = v;
        bus.fft_last  = l;
        bus.fft_k     = cur_k;
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        if (reset_n && !exp_busy(cyc) && cur_v && cur_l) read_start = cyc + 1;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    task automatic idle_noisy(input int n);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2 * N - 1));
    endtask

    task automatic short_frame(input int n, input int last_k);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, $urandom_range(0, 2 * N - 1));
        cycle(1'b1, 1'b1, last_k);
    endtask

    task automatic clear_counts();
        reads_seen = 0;
        we_seen    = 0;
        done_seen  = 0;
    endtask

    initial begin
        bus.fft_valid = 1'b0;
        bus.fft_last  = 1'b0;
        bus.fft_k     = '0;

        // Power-on reset: all outputs low
        idle(3);
        reset_n = 1'b1;
        idle(3);

        // Full frame of 2048 bins with random gaps
        clear_counts();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 0);
            cycle(1'b1, k == N - 1, k);
        end
        idle(R + LAT);
        chk("full_we_count", we_seen, N);
        chk("full_read_count", reads_seen, R);
        chk("full_done_count", done_seen, 1);
        idle(2);

        // Upper-half bins are not written but the last one still ends the frame; noisy overruns during read
        clear_counts();
        cycle(1'b1, 1'b0, 2100);
        chk("upper_no_we", we_seen, 0);
        short_frame(20, 2100);
        idle_noisy(R + LAT);
        chk("upper_read_count", reads_seen, R);
        chk("upper_done_count", done_seen, 1);
        idle(2);

        // Reset in the middle of the k=300 reads
        short_frame(4, $urandom_range(0, N - 1));
        idle((300 - KMIN) * H + 1);
        reset_n    = 1'b0;
        read_start = -1;
        idle(3);
        reset_n = 1'b1;
        idle(LAT + 5);

        // Clean frame after reset, then a back-to-back frame right after frame_done
        clear_counts();
        short_frame(9, $urandom_range(0, N - 1));
        idle(R + LAT);
        chk("b2b_done_count", done_seen, 1);
        clear_counts();
        cycle(1'b1, 1'b0, 7);
        chk("b2b_accept", we_seen, 1);
        short_frame(5, $urandom_range(0, N - 1));
        idle_noisy(R + LAT);
        chk("b2b_read_count", reads_seen, R);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
